// File: rtl/fe_pkg.sv
// Shared constants and types for the word-serial field adder/subtractor.
package fe_pkg;

    localparam int unsigned W  = 17;
    localparam int unsigned N  = 15;
    localparam int unsigned C  = 19;
    localparam int unsigned FW = N * W;

    // P = 2^FW - C, formed as the two's-complement of C in FW bits
    localparam logic [FW-1:0] P = FW'(0) - FW'(C);

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/fe_limb_addsub.sv
// One-limb, two-lane add/subtract unit: lane0 forms a+b or a-b, lane1 applies -P or +P.
module fe_limb_addsub #(
    parameter int unsigned W = fe_pkg::W
) (
    input  logic         op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] p_i,
    input  logic         c0_i,
    input  logic         c1_i,
    output logic [W-1:0] r0_c,
    output logic [W-1:0] r1_c,
    output logic         c0_c,
    output logic         c1_c
);
    import fe_pkg::*;

    localparam int unsigned WX = W + 1;

    logic [W:0] lane0;
    logic [W:0] lane1;

    // Bit W of each lane is its outgoing carry (add) or borrow (sub)
    always_comb begin
        lane0 = '0;
        lane1 = '0;
        if (op_i == OP_SUB) begin
            lane0 = {1'b0, a_i} - {1'b0, b_i} - WX'(c0_i);
            lane1 = {1'b0, lane0[W-1:0]} + {1'b0, p_i} + WX'(c1_i);
        end else begin
            lane0 = {1'b0, a_i} + {1'b0, b_i} + WX'(c0_i);
            lane1 = {1'b0, lane0[W-1:0]} - {1'b0, p_i} - WX'(c1_i);
        end
    end

    assign r0_c = lane0[W-1:0];
    assign r1_c = lane1[W-1:0];
    assign c0_c = lane0[W];
    assign c1_c = lane1[W];

endmodule

// File: rtl/feaddsub.sv
// Word-serial modular adder/subtractor over GF(2^(N*W) - C), one limb per cycle, LSB first.
module feaddsub #(
    parameter int unsigned W    = fe_pkg::W,
    parameter int unsigned N    = fe_pkg::N,
    parameter int unsigned C    = fe_pkg::C,
    parameter int unsigned LOGN = $clog2(N + 1)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic            op,
    input  logic [N*W-1:0]  a_in,
    input  logic [N*W-1:0]  b_in,
    output logic            busy,
    output logic            done,
    output logic [N*W-1:0]  out
);
    import fe_pkg::*;

    localparam int unsigned    FW   = N * W;
    localparam logic [FW-1:0]  PMOD = FW'(0) - FW'(C);

    state_e          state_q, state_d;
    logic [LOGN-1:0] cnt_q, cnt_d;
    logic            op_q, op_d;
    logic [FW-1:0]   a_q, a_d, b_q, b_d;
    logic [FW-1:0]   r0_q, r0_d, r1_q, r1_d;
    logic            c0_q, c0_d, c1_q, c1_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [FW-1:0]   out_q, out_d;

    logic [W-1:0]    p_limb;
    logic [W-1:0]    r0_c, r1_c;
    logic            c0_c, c1_c;
    logic            sel_alt_c;

    fe_limb_addsub #(.W(W)) u_limb (
        .op_i (op_q),
        .a_i  (a_q[W-1:0]),
        .b_i  (b_q[W-1:0]),
        .p_i  (p_limb),
        .c0_i (c0_q),
        .c1_i (c1_q),
        .r0_c (r0_c),
        .r1_c (r1_c),
        .c0_c (c0_c),
        .c1_c (c1_c)
    );

    // Modulus limb for the current counter value
    always_comb begin
        p_limb = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (cnt_q == LOGN'(i)) p_limb = PMOD[i*W +: W];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        r0_d      = r0_q;
        r1_d      = r1_q;
        c0_d      = c0_q;
        c1_d      = c1_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        out_d     = out_q;
        sel_alt_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    op_d    = op;
                    a_d     = a_in;
                    b_d     = b_in;
                    c0_d    = 1'b0;
                    c1_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                a_d  = a_q >> W;
                b_d  = b_q >> W;
                r0_d = {r0_c, r0_q[FW-1:W]};
                r1_d = {r1_c, r1_q[FW-1:W]};
                c0_d = c0_c;
                c1_d = c1_c;
                cnt_d = cnt_q + LOGN'(1);
                if (cnt_q == LOGN'(N - 1)) begin
                    // add: sum >= P takes lane1; sub: a < b takes lane1 (d + P)
                    sel_alt_c = (op_q == OP_SUB) ? c0_c : (c0_c | ~c1_c);
                    out_d     = sel_alt_c ? r1_d : r0_d;
                    state_d   = ST_IDLE;
                    cnt_d     = LOGN'(N);
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= LOGN'(N);
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            r0_q    <= '0;
            r1_q    <= '0;
            c0_q    <= 1'b0;
            c1_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r0_q    <= r0_d;
            r1_q    <= r1_d;
            c0_q    <= c0_d;
            c1_q    <= c1_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_feaddsub.sv
// Directed and random checks of feaddsub at default size and at W=8,N=4,C=5.
module tb_feaddsub;

    localparam int unsigned    FW = 255;
    localparam logic [FW-1:0]  P  = FW'(0) - FW'(19);
    localparam longint unsigned SP = 64'h1_0000_0000 - 64'd5;

    logic          clock;
    logic          reset_n;
    logic          start, op;
    logic [FW-1:0] a_in, b_in, out;
    logic          busy, done;

    logic          s_start, s_op;
    logic [31:0]   s_a, s_b, s_out;
    logic          s_busy, s_done;

    int n_tests = 0;
    int n_fail  = 0;

    feaddsub u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy),
        .done    (done),
        .out     (out)
    );

    feaddsub #(.W(8), .N(4), .C(5)) u_small (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (s_start),
        .op      (s_op),
        .a_in    (s_a),
        .b_in    (s_b),
        .busy    (s_busy),
        .done    (s_done),
        .out     (s_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic o, input logic [FW-1:0] a, input logic [FW-1:0] b,
                         output logic [FW-1:0] r, output int lat, output int bcnt);
        @(negedge clock);
        start = 1'b1; op = o; a_in = a; b_in = b;
        @(posedge clock); #1;
        start = 1'b0;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 64) begin
            @(posedge clock); #1;
            lat++;
            if (busy) bcnt++;
        end
        r = out;
    endtask

    task automatic run_chk(input string tag, input logic o, input logic [FW-1:0] a,
                           input logic [FW-1:0] b, input logic [FW-1:0] exp);
        logic [FW-1:0] r;
        int lat, bcnt;
        do_op(o, a, b, r, lat, bcnt);
        check(tag, r, exp);
        check({tag, "_lat"}, FW'(lat), FW'(15));
    endtask

    task automatic small_chk(input string tag, input logic o, input longint unsigned a,
                             input longint unsigned b);
        longint unsigned exp;
        int lat;
        exp = (o == 1'b0) ? (a + b) % SP : (a + SP - b) % SP;
        @(negedge clock);
        s_start = 1'b1; s_op = o; s_a = 32'(a); s_b = 32'(b);
        @(posedge clock); #1;
        s_start = 1'b0;
        lat = 0;
        while (!s_done && lat < 32) begin
            @(posedge clock); #1;
            lat++;
        end
        check(tag, FW'(s_out), FW'(exp));
    endtask

    initial begin
        logic [FW-1:0]   r, got, h, x;
        int              lat, bcnt, dones;
        longint unsigned ra, rb;

        reset_n = 1'b0;
        start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
        s_start = 1'b0; s_op = 1'b0; s_a = '0; s_b = '0;
        #23;
        check("rst_busy", FW'(busy), FW'(0));
        check("rst_done", FW'(done), FW'(0));
        check("rst_out",  out, FW'(0));
        check("rst_small_out", FW'(s_out), FW'(0));
        @(negedge clock);
        reset_n = 1'b1;

        do_op(1'b0, FW'(1), FW'(2), r, lat, bcnt);
        check("add_1_2", r, FW'(3));
        check("add_1_2_lat", FW'(lat), FW'(15));
        check("add_1_2_busy_cycles", FW'(bcnt), FW'(15));
        check("add_1_2_busy_at_done", FW'(busy), FW'(0));

        h = FW'(1) << 254;
        x = 255'h1234_5678_9abc_def0_1122_3344_5566_7788;
        run_chk("add_pm1_1",   1'b0, P - FW'(1), FW'(1), FW'(0));
        run_chk("add_pm1_pm1", 1'b0, P - FW'(1), P - FW'(1), P - FW'(2));
        run_chk("add_h_h",     1'b0, h, h, FW'(19));
        run_chk("sub_5_3",     1'b1, FW'(5), FW'(3), FW'(2));
        run_chk("sub_0_1",     1'b1, FW'(0), FW'(1), P - FW'(1));
        run_chk("sub_3_5",     1'b1, FW'(3), FW'(5), P - FW'(2));
        run_chk("sub_x_x",     1'b1, x, x, FW'(0));

        // start pulsed mid-operation must be ignored
        @(negedge clock);
        start = 1'b1; op = 1'b0; a_in = FW'(7); b_in = FW'(8);
        @(posedge clock); #1;
        start = 1'b0;
        dones = 0; got = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (c == 5) begin
                start = 1'b1; a_in = FW'(100); b_in = FW'(200);
            end else begin
                start = 1'b0;
            end
            @(posedge clock); #1;
            if (done) begin
                dones++;
                got = out;
            end
        end
        check("ignore_start_dones", FW'(dones), FW'(1));
        check("ignore_start_out", got, FW'(15));

        // reset mid-operation aborts
        @(negedge clock);
        start = 1'b1; op = 1'b0; a_in = FW'(9); b_in = FW'(9);
        @(posedge clock); #1;
        start = 1'b0;
        repeat (7) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("abort_busy", FW'(busy), FW'(0));
        check("abort_done", FW'(done), FW'(0));
        check("abort_out",  out, FW'(0));
        @(negedge clock);
        reset_n = 1'b1;
        dones = 0;
        repeat (25) begin
            @(posedge clock); #1;
            if (done) dones++;
        end
        check("abort_no_done", FW'(dones), FW'(0));
        run_chk("add_4_4_after_abort", 1'b0, FW'(4), FW'(4), FW'(8));

        small_chk("s_add_max", 1'b0, SP - 1, SP - 1);
        small_chk("s_sub_0_1", 1'b1, 0, 1);
        small_chk("s_add_wrap", 1'b0, SP - 1, 1);
        for (int i = 0; i < 3000; i++) begin
            ra = 64'($urandom) % SP;
            rb = 64'($urandom) % SP;
            small_chk("s_rand", 1'($urandom), ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
